// File: rtl/alu_ctrl_seq_pkg.sv
// Shared constants for the ALU control sequencer: control codes, aluop and
// R-type funct encodings, and the sequencer state type.
package alu_ctrl_pkg;

    localparam logic [4:0] CTRL_ADD  = 5'b00000;
    localparam logic [4:0] CTRL_AND  = 5'b00001;
    localparam logic [4:0] CTRL_XOR  = 5'b00010;
    localparam logic [4:0] CTRL_SLL  = 5'b00011;
    localparam logic [4:0] CTRL_SRL  = 5'b00111;
    localparam logic [4:0] CTRL_SRA  = 5'b01111;
    localparam logic [4:0] CTRL_COMP = 5'b01100;
    localparam logic [4:0] CTRL_DIFF = 5'b10000;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SLL   = 3'b001;
    localparam logic [2:0] OP_SRL   = 3'b010;
    localparam logic [2:0] OP_SRA   = 3'b011;
    localparam logic [2:0] OP_COMP  = 3'b100;
    localparam logic [2:0] OP_DIFF  = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;
    localparam logic [2:0] OP_RTYPE = 3'b111;

    localparam int unsigned FN_ADD  = 1;
    localparam int unsigned FN_COMP = 2;
    localparam int unsigned FN_AND  = 3;
    localparam int unsigned FN_XOR  = 4;
    localparam int unsigned FN_DIFF = 5;
    localparam int unsigned FN_SLL  = 6;
    localparam int unsigned FN_SRL  = 7;
    localparam int unsigned FN_SRA  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_STEP
    } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/beat handshake bundle between main control (master) and the
// ALU control sequencer (slave).
interface alu_ctrl_seq_if #(
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         aluop;
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         ctrl;
    logic [SHAMT_W-1:0] step_shamt;
    logic               first;
    logic               last;
    logic               illegal;

    modport master (
        output in_valid, aluop, funct, shamt, out_ready,
        input  in_ready, out_valid, ctrl, step_shamt, first, last, illegal
    );

    modport slave (
        input  in_valid, aluop, funct, shamt, out_ready,
        output in_ready, out_valid, ctrl, step_shamt, first, last, illegal
    );
endinterface

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational aluop/funct decoder producing the ALU control code, a shift
// flag and an illegal-op flag (illegal ops decode as ADD).
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W = 6
) (
    input  logic [2:0]         aluop_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [4:0]         ctrl_o,
    output logic               is_shift_o,
    output logic               illegal_o
);

    logic [31:0] funct_x;
    assign funct_x = 32'(funct_i);

    always_comb begin
        ctrl_o    = CTRL_ADD;
        illegal_o = 1'b0;
        case (aluop_i)
            OP_ADD:  ctrl_o = CTRL_ADD;
            OP_SLL:  ctrl_o = CTRL_SLL;
            OP_SRL:  ctrl_o = CTRL_SRL;
            OP_SRA:  ctrl_o = CTRL_SRA;
            OP_COMP: ctrl_o = CTRL_COMP;
            OP_DIFF: ctrl_o = CTRL_DIFF;
            OP_ILL:  illegal_o = 1'b1;
            OP_RTYPE: begin
                case (funct_x)
                    FN_ADD:  ctrl_o = CTRL_ADD;
                    FN_COMP: ctrl_o = CTRL_COMP;
                    FN_AND:  ctrl_o = CTRL_AND;
                    FN_XOR:  ctrl_o = CTRL_XOR;
                    FN_DIFF: ctrl_o = CTRL_DIFF;
                    FN_SLL:  ctrl_o = CTRL_SLL;
                    FN_SRL:  ctrl_o = CTRL_SRL;
                    FN_SRA:  ctrl_o = CTRL_SRA;
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end

    assign is_shift_o = (ctrl_o == CTRL_SLL) || (ctrl_o == CTRL_SRL) || (ctrl_o == CTRL_SRA);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: decodes each request and issues it as one
// beat, or as shamt single-bit steps when MULTI_SHIFT is set.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W     = 6,
    parameter int unsigned SHAMT_W     = 5,
    parameter bit          MULTI_SHIFT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_ctrl_seq_if.slave  bus
);

    state_e             state_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] step_q;
    logic [4:0]         ctrl_q;
    logic               first_q;
    logic               last_q;
    logic               illegal_q;

    logic [4:0] dec_ctrl;
    logic       dec_shift;
    logic       dec_illegal;
    logic       consume;
    logic       accept;
    logic       multi;
    logic       shamt_one;

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .aluop_i    (bus.aluop),
        .funct_i    (bus.funct),
        .ctrl_o     (dec_ctrl),
        .is_shift_o (dec_shift),
        .illegal_o  (dec_illegal)
    );

    // last_q is only ever set in HOLD, so "consuming a last beat" frees the slot.
    assign consume   = (state_q != ST_IDLE) && bus.out_ready;
    assign bus.in_ready = !rst && ((state_q == ST_IDLE) || (consume && last_q));
    assign accept    = bus.in_valid && bus.in_ready;
    assign multi     = MULTI_SHIFT && dec_shift && (bus.shamt != '0);
    assign shamt_one = (bus.shamt == SHAMT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            step_q    <= '0;
            ctrl_q    <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
            first_q   <= 1'b1;
            if (multi) begin
                step_q  <= SHAMT_W'(1);
                rem_q   <= bus.shamt - 1'b1;
                last_q  <= shamt_one;
                state_q <= shamt_one ? ST_HOLD : ST_STEP;
            end else begin
                step_q  <= dec_shift ? bus.shamt : '0;
                rem_q   <= '0;
                last_q  <= 1'b1;
                state_q <= ST_HOLD;
            end
        end else if (consume) begin
            case (state_q)
                ST_STEP: begin
                    // rem_q counts beats still to come after the one just consumed
                    rem_q   <= rem_q - 1'b1;
                    first_q <= 1'b0;
                    last_q  <= (rem_q == SHAMT_W'(1));
                    state_q <= (rem_q == SHAMT_W'(1)) ? ST_HOLD : ST_STEP;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    step_q    <= '0;
                    ctrl_q    <= '0;
                    first_q   <= 1'b0;
                    last_q    <= 1'b0;
                    illegal_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid  = (state_q != ST_IDLE);
    assign bus.ctrl       = ctrl_q;
    assign bus.step_shamt = step_q;
    assign bus.first      = first_q;
    assign bus.last       = last_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: one multi-step and one single-beat
// instance share stimulus; vectors, corner sequences and a randomized model.
module tb_alu_ctrl_seq;

    localparam int unsigned FW = 6;
    localparam int unsigned SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [2:0]    aluop;
    logic [FW-1:0] funct;
    logic [SW-1:0] shamt;
    logic          out_ready;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq_if #(.FUNCT_W(FW), .SHAMT_W(SW)) bus0 ();
    alu_ctrl_seq_if #(.FUNCT_W(FW), .SHAMT_W(SW)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.aluop     = aluop;
    assign bus0.funct     = funct;
    assign bus0.shamt     = shamt;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.aluop     = aluop;
    assign bus1.funct     = funct;
    assign bus1.shamt     = shamt;
    assign bus1.out_ready = out_ready;

    alu_ctrl_seq #(.FUNCT_W(FW), .SHAMT_W(SW), .MULTI_SHIFT(1'b1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    alu_ctrl_seq #(.FUNCT_W(FW), .SHAMT_W(SW), .MULTI_SHIFT(1'b0)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        logic [4:0] ctrl;
        logic [4:0] step;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [4:0] ctrl;
        logic [4:0] step;
        logic       first;
        logic       last;
        logic       ill;
    } beat_t;

    vec_t  vecs[$];
    beat_t q0[$];
    beat_t q1[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input int unsigned d, input string nm, input logic v,
                            input logic [4:0] c, input logic [4:0] s,
                            input logic f, input logic l, input logic il);
        logic [13:0] act;
        if (d == 0) act = {bus0.out_valid, bus0.ctrl, bus0.step_shamt, bus0.first, bus0.last, bus0.illegal};
        else        act = {bus1.out_valid, bus1.ctrl, bus1.step_shamt, bus1.first, bus1.last, bus1.illegal};
        chk(nm, 32'(act), 32'({v, c, s, f, l, il}));
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh);
        in_valid = v;
        aluop    = op;
        funct    = fn;
        shamt    = sh;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    // Returns {illegal, ctrl} straight from the opcode tables.
    function automatic logic [5:0] ref_dec(input logic [2:0] op, input logic [5:0] fn);
        logic [4:0] op_tab [8];
        logic [4:0] fn_tab [9];
        op_tab = '{5'b00000, 5'b00011, 5'b00111, 5'b01111, 5'b01100, 5'b10000, 5'b00000, 5'b00000};
        fn_tab = '{5'b00000, 5'b00000, 5'b01100, 5'b00001, 5'b00010, 5'b10000, 5'b00011, 5'b00111, 5'b01111};
        if (op == 3'd6) return 6'b100000;
        if (op != 3'd7) return {1'b0, op_tab[op]};
        if (fn == 6'd0 || fn > 6'd8) return 6'b100000;
        return {1'b0, fn_tab[fn[3:0]]};
    endfunction

    task automatic model_step(input int unsigned d);
        beat_t       q[$];
        beat_t       b;
        logic        rdy;
        logic        vld;
        logic [12:0] act;
        logic [5:0]  dec;
        logic        is_sh;
        if (d == 0) begin
            q = q0; rdy = bus0.in_ready; vld = bus0.out_valid;
            act = {bus0.ctrl, bus0.step_shamt, bus0.first, bus0.last, bus0.illegal};
        end else begin
            q = q1; rdy = bus1.in_ready; vld = bus1.out_valid;
            act = {bus1.ctrl, bus1.step_shamt, bus1.first, bus1.last, bus1.illegal};
        end
        chk("rand_in_ready", 32'(rdy), 32'((q.size() == 0) || (q.size() == 1 && out_ready)));
        chk("rand_out_valid", 32'(vld), 32'(q.size() != 0));
        if (vld && q.size() != 0) begin
            b = q[0];
            chk("rand_beat", 32'(act), 32'({b.ctrl, b.step, b.first, b.last, b.ill}));
            if (out_ready) void'(q.pop_front());
        end
        if (in_valid && rdy) begin
            dec   = ref_dec(aluop, funct);
            is_sh = (dec[4:0] == 5'b00011) || (dec[4:0] == 5'b00111) || (dec[4:0] == 5'b01111);
            if (d == 0 && is_sh && shamt != 0) begin
                for (int i = 0; i < int'(shamt); i++)
                    q.push_back('{dec[4:0], 5'd1, (i == 0), (i == int'(shamt) - 1), dec[5]});
            end else begin
                q.push_back('{dec[4:0], is_sh ? shamt : 5'd0, 1'b1, 1'b1, dec[5]});
            end
        end
        if (d == 0) q0 = q;
        else        q1 = q;
    endtask

    initial begin
        logic [4:0] exp_ctrl [3];
        logic       exp_first [3];
        logic       exp_last [3];
        logic       exp_rdy [3];
        int unsigned beats;
        int unsigned lasts;
        logic        last_on_final;

        rst = 1'b1;
        req(1'b0, 3'd0, 6'd0, 5'd0);
        out_ready = 1'b0;
        adv();
        adv();
        settle();
        chk_beat(0, "reset_outputs0", 0, 5'd0, 5'd0, 0, 0, 0);
        chk_beat(1, "reset_outputs1", 0, 5'd0, 5'd0, 0, 0, 0);
        chk("reset_in_ready", 32'(bus0.in_ready), 32'd0);
        adv();
        rst = 1'b0;

        // Single-beat decode table, checked on the full-amount shifter instance.
        vecs.push_back('{3'd0, 6'd0,  5'd5,  5'b00000, 5'd0,  1'b0});
        vecs.push_back('{3'd1, 6'd0,  5'd7,  5'b00011, 5'd7,  1'b0});
        vecs.push_back('{3'd2, 6'd0,  5'd3,  5'b00111, 5'd3,  1'b0});
        vecs.push_back('{3'd3, 6'd0,  5'd0,  5'b01111, 5'd0,  1'b0});
        vecs.push_back('{3'd4, 6'd0,  5'd9,  5'b01100, 5'd0,  1'b0});
        vecs.push_back('{3'd5, 6'd0,  5'd1,  5'b10000, 5'd0,  1'b0});
        vecs.push_back('{3'd6, 6'd0,  5'd4,  5'b00000, 5'd0,  1'b1});
        vecs.push_back('{3'd7, 6'd1,  5'd2,  5'b00000, 5'd0,  1'b0});
        vecs.push_back('{3'd7, 6'd2,  5'd2,  5'b01100, 5'd0,  1'b0});
        vecs.push_back('{3'd7, 6'd3,  5'd2,  5'b00001, 5'd0,  1'b0});
        vecs.push_back('{3'd7, 6'd4,  5'd2,  5'b00010, 5'd0,  1'b0});
        vecs.push_back('{3'd7, 6'd5,  5'd2,  5'b10000, 5'd0,  1'b0});
        vecs.push_back('{3'd7, 6'd6,  5'd2,  5'b00011, 5'd2,  1'b0});
        vecs.push_back('{3'd7, 6'd7,  5'd3,  5'b00111, 5'd3,  1'b0});
        vecs.push_back('{3'd7, 6'd8,  5'd31, 5'b01111, 5'd31, 1'b0});
        vecs.push_back('{3'd7, 6'd9,  5'd1,  5'b00000, 5'd0,  1'b1});
        vecs.push_back('{3'd7, 6'd0,  5'd1,  5'b00000, 5'd0,  1'b1});
        vecs.push_back('{3'd7, 6'd63, 5'd1,  5'b00000, 5'd0,  1'b1});

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            req(1'b1, vecs[i].op, vecs[i].fn, vecs[i].sh);
            settle();
            chk("vec_in_ready", 32'(bus1.in_ready), 32'd1);
            adv();
            in_valid = 1'b0;
            settle();
            chk_beat(1, $sformatf("vec%0d", i), 1, vecs[i].ctrl, vecs[i].step, 1, 1, vecs[i].ill);
            adv();
        end

        // SRA with zero amount on the stepping instance: a single plain beat.
        do_reset();
        out_ready = 1'b1;
        req(1'b1, 3'd3, 6'd0, 5'd0);
        settle();
        adv();
        in_valid = 1'b0;
        settle();
        chk_beat(0, "sra_shamt0", 1, 5'b01111, 5'd0, 1, 1, 0);
        adv();
        settle();
        chk("sra_shamt0_idle", 32'(bus0.out_valid), 32'd0);
        adv();

        // Back-to-back R-type AND, XOR, ADD.
        req(1'b1, 3'd7, 6'd3, 5'd0);
        settle();
        chk("b2b_ready0", 32'(bus0.in_ready), 32'd1);
        adv();
        req(1'b1, 3'd7, 6'd4, 5'd0);
        settle();
        chk_beat(0, "b2b_and", 1, 5'b00001, 5'd0, 1, 1, 0);
        chk("b2b_ready1", 32'(bus0.in_ready), 32'd1);
        adv();
        req(1'b1, 3'd7, 6'd1, 5'd0);
        settle();
        chk_beat(0, "b2b_xor", 1, 5'b00010, 5'd0, 1, 1, 0);
        adv();
        in_valid = 1'b0;
        settle();
        chk_beat(0, "b2b_add", 1, 5'b00000, 5'd0, 1, 1, 0);
        adv();
        settle();
        chk("b2b_idle", 32'(bus0.out_valid), 32'd0);
        adv();

        // SRL by 3 in steps, with an ADD request waiting behind it.
        exp_ctrl  = '{5'b00111, 5'b00111, 5'b00111};
        exp_first = '{1'b1, 1'b0, 1'b0};
        exp_last  = '{1'b0, 1'b0, 1'b1};
        exp_rdy   = '{1'b0, 1'b0, 1'b1};
        req(1'b1, 3'd7, 6'd7, 5'd3);
        settle();
        chk("srl3_ready_idle", 32'(bus0.in_ready), 32'd1);
        adv();
        req(1'b1, 3'd0, 6'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_beat(0, $sformatf("srl3_beat%0d", i), 1, exp_ctrl[i], 5'd1, exp_first[i], exp_last[i], 0);
            chk($sformatf("srl3_ready%0d", i), 32'(bus0.in_ready), 32'(exp_rdy[i]));
            if (i == 0) chk_beat(1, "srl3_full", 1, 5'b00111, 5'd3, 1, 1, 0);
            adv();
        end
        in_valid = 1'b0;
        settle();
        chk_beat(0, "srl3_next_add", 1, 5'b00000, 5'd0, 1, 1, 0);
        adv();
        settle();
        chk("srl3_idle", 32'(bus0.out_valid), 32'd0);
        adv();

        // SLL by 4 with a 4-cycle stall after the first step.
        req(1'b1, 3'd1, 6'd0, 5'd4);
        settle();
        adv();
        in_valid = 1'b0;
        settle();
        chk_beat(0, "stall_beat1", 1, 5'b00011, 5'd1, 1, 0, 0);
        adv();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_beat(0, $sformatf("stall_frozen%0d", i), 1, 5'b00011, 5'd1, 0, 0, 0);
            adv();
        end
        out_ready = 1'b1;
        beats = 0;
        lasts = 0;
        last_on_final = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (bus0.out_valid) begin
                beats++;
                last_on_final = bus0.last;
                if (bus0.last) lasts++;
            end
            adv();
        end
        chk("stall_remaining_beats", beats, 32'd3);
        chk("stall_last_count", lasts, 32'd1);
        chk("stall_last_final", 32'(last_on_final), 32'd1);

        // Reset during the third step of a 5-step SLL.
        req(1'b1, 3'd1, 6'd0, 5'd5);
        settle();
        adv();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (i < 2) adv();
        end
        chk_beat(0, "rstmid_beat3", 1, 5'b00011, 5'd1, 0, 0, 0);
        rst = 1'b1;
        adv();
        settle();
        chk_beat(0, "rstmid_cleared", 0, 5'd0, 5'd0, 0, 0, 0);
        chk("rstmid_in_ready", 32'(bus0.in_ready), 32'd0);
        adv();
        rst = 1'b0;
        req(1'b1, 3'd0, 6'd0, 5'd0);
        settle();
        chk("rstmid_ready_after", 32'(bus0.in_ready), 32'd1);
        adv();
        in_valid = 1'b0;
        settle();
        chk_beat(0, "rstmid_fresh", 1, 5'b00000, 5'd0, 1, 1, 0);
        adv();
        settle();
        chk("rstmid_no_leftover", 32'(bus0.out_valid), 32'd0);
        adv();

        // Randomized traffic on both instances against the beat-queue model.
        do_reset();
        q0.delete();
        q1.delete();
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            aluop     = 3'($urandom_range(0, 7));
            funct     = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 10));
            shamt     = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            model_step(0);
            model_step(1);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered successor to the combinational ALU control decoder in the KGP-RISC datapath. Decodes `aluop`/`funct` into the 5-bit ALU control code and, when `MULTI_SHIFT=1`, breaks each shift into single-bit steps, one per beat, so the ALU needs only a 1-bit shifter. A valid/ready handshake sits on both sides. The block sits between the main control unit and the ALU and drives the ALU operand-feedback select.

## Interface
- `FUNCT_W`, 6: width of the R-type function field.
- `SHAMT_W`, 5: width of the shift amount (data width = 2^SHAMT_W).
- `MULTI_SHIFT`, 1: 1 issues shifts as 1-bit steps; 0 issues each shift as one beat with the full amount.
- `clk  in  1`: the single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: request present.
- `in_ready  out  1`: request accepted when `in_valid && in_ready` at a rising edge.
- `aluop  in  3`: ALU operation class from main control.
- `funct  in  FUNCT_W`: R-type function code.
- `shamt  in  SHAMT_W`: shift amount, from the immediate or rt[SHAMT_W-1:0].
- `out_valid  out  1`: beat present on the outputs.
- `out_ready  in  1`: ALU consumes the beat when `out_valid && out_ready`.
- `ctrl  out  5`: ALU control code.
- `step_shamt  out  SHAMT_W`: shift amount for this beat.
- `first  out  1`: 1 selects register operands; 0 selects the ALU result fed back.
- `last  out  1`: final beat of the operation; the ALU writes back only on this beat.
- `illegal  out  1`: the op decoded as undefined; the beat carries ADD.

## Operation
- Control codes: ADD 00000, AND 00001, XOR 00010, SLL 00011, SRL 00111, SRA 01111, COMP 01100, DIFF 10000.
- `aluop` decode:
  - 000 → ADD.
  - 001 → SLL.
  - 010 → SRL.
  - 011 → SRA.
  - 100 → COMP.
  - 101 → DIFF.
  - 110 → ADD with `illegal=1`.
  - 111 → R-type, decoded from `funct`.
- R-type `funct` decode (zero-extended to `FUNCT_W`):
  - 1 → ADD; 2 → COMP; 3 → AND; 4 → XOR.
  - 5 → DIFF; 6 → SLL; 7 → SRL; 8 → SRA.
  - Any other value → ADD with `illegal=1`.
- States:
  - IDLE: no beat held.
  - HOLD: single-beat op, or the final shift step, is held.
  - STEP: multi-beat shift in progress.
- Non-shift op, shift with `shamt=0`, or any shift with `MULTI_SHIFT=0`:
  - Exactly one beat, with `first=last=1`.
  - `step_shamt` equals `shamt` for shifts and 0 for all other ops.
- Shift with `MULTI_SHIFT=1` and `shamt=k>0`:
  - k beats, each with the shift code and `step_shamt=1`.
  - `first=1` on beat 1 only; `last=1` on beat k only.
  - A remaining-count register (SHAMT_W bits) loads k−1 on accept and decrements on each consumed beat. It never wraps.
- `in_ready` is 1 in IDLE, and also when the held beat is `last` and is consumed this cycle (back-to-back issue). It is 0 in all other cases, including while `rst` is high.
- Outputs stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`, `first`, `last` and `illegal` are 0; `ctrl` is 00000; `step_shamt` is 0; state is IDLE.
- Reset asserted mid-sequence aborts the operation. Remaining beats are discarded and no `last` is issued.
- Latency: an accept at edge N drives `out_valid=1` from edge N (visible during cycle N+1).
- Single-beat ops sustain one accept per cycle when `out_ready` is held high.
- A shift of k issues k beats, the last at edge N+k−1 when `out_ready` is always high. The next accept coincides with consumption of the `last` beat.
- `out_ready` low freezes the current beat, the count and the state.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the control-code localparams;
  - the `aluop` encodings;
  - the R-type `funct` codes;
  - the state enum.
- Sub-module `alu_ctrl_decode` is purely combinational: (`aluop`, `funct`) → (`ctrl`, `is_shift`, `illegal`). It is instantiated once, and the sequencer registers its outputs.

## Test plan
- Reset asserted during cycle 3 of a 5-step SLL → next cycle all outputs are at reset values; after release the next accept starts cleanly with `first=1`.
- Back-to-back `aluop=111` with `funct`=3, then 4, then 1, `out_ready=1` → ctrl sequence 00001, 00010, 00000 on consecutive cycles, each beat with `first=last=1`.
- `aluop=111`, `funct=7`, `shamt=3`, `MULTI_SHIFT=1` → three beats of ctrl 00111, `step_shamt=1`, `first` pattern 1,0,0, `last` pattern 0,0,1; `in_ready=0` for the two middle cycles.
- Same request with `MULTI_SHIFT=0` → one beat: ctrl 00111, `step_shamt=3`, `first=last=1`.
- `aluop=011`, `shamt=0` → one beat: ctrl 01111, `step_shamt=0`, `first=last=1`.
- `aluop=111`, `funct=9` → ctrl 00000 with `illegal=1`. Separately, `out_ready` held low for 4 cycles mid-shift → outputs and the remaining count stay frozen, and no beat is lost or duplicated.
